layer_ctrl_gen: RTL
===================

# layer_ctrl_gen

Parametrised convolution-layer controller for the SqueezeNext accelerator, replacing the per-layer hand-sized controllers. It walks output channel, output row, output column, input channel and kernel taps with nested counters. It drives feature-map BRAM read and write addresses, the weight ROM address, the padding flag and the accumulator-clear strobe. Write-back is delayed to match a configurable MAC pipeline depth, and a start/done handshake sequences layers.

## Interface
Parameters:
- FM_W, 6, output feature-map width (same-size padding, stride 1)
- FM_H, 6, output feature-map height
- CIN, 8, input channels
- COUT, 16, output channels
- KW, 3, kernel width (odd, 1..7)
- KH, 3, kernel height (odd, 1..7)
- PIPE, 5, cycles from tap issue to MAC result valid (>=1)
- AW, 10, feature-map BRAM address width
- WAW, 11, weight address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run the layer; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  tap valid
- rd_addr  out  AW  input feature-map read address
- w_addr  out  WAW  weight address
- padding  out  1  tap lies outside the input map; MAC uses zero
- load  out  1  first tap of an output pixel; accumulator clears
- wr_en  out  1  output pixel result valid
- wr_addr  out  AW  output feature-map write address
- rd_bank  out  1  feature-map bank read this layer
- wr_bank  out  1  feature-map bank written this layer

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset goes to IDLE.
- IDLE: start=1 moves to RUN and clears all counters. Otherwise stay.
- RUN: one tap per cycle. Counter order, innermost first, is kx, ky, ci, x, y, oc. Each counter wraps to 0 and carries to the next.
- RUN moves to DRAIN after the tap oc=COUT-1, y=FM_H-1, x=FM_W-1, ci=CIN-1, ky=KH-1, kx=KW-1.
- DRAIN: stay PIPE cycles, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Padding offsets: PX=KW/2, PY=KH/2. Input coordinates: iy=y+ky-PY, ix=x+kx-PX, computed signed, one bit wider than the counters.
- padding=1 when iy<0, iy>=FM_H, ix<0 or ix>=FM_W. In that case rd_addr=0.
- Otherwise rd_addr = ci*FM_H*FM_W + iy*FM_W + ix.
- w_addr = ((oc*CIN+ci)*KH+ky)*KW+kx.
- load=1 when ci=0, ky=0 and kx=0 in RUN.
- Last tap of a pixel is ci=CIN-1, ky=KH-1, kx=KW-1. On that tap, oc*FM_H*FM_W + y*FM_W + x enters a PIPE-stage shift register together with a valid bit. The shift-register output drives wr_addr and wr_en.
- Address arithmetic is truncated to AW/WAW bits. Sizing the widths is the integrator's job; there is no overflow detection.
- start while busy: ignored, no restart.
- rst mid-layer: FSM returns to IDLE, counters and delay line clear, and no wr_en is emitted afterwards.

## Timing
- Reset values: busy, done, rd_en, padding, load, wr_en = 0; rd_addr, w_addr, wr_addr = 0; rd_bank=0, wr_bank=1.
- start sampled at edge T0. RUN spans cycles 1..N, where N = COUT*FM_H*FM_W*CIN*KH*KW.
- rd_en, rd_addr, w_addr, padding and load are combinational from registered counters. They are valid in the same cycle as the tap.
- wr_en for a pixel whose last tap is in cycle t asserts in cycle t+PIPE.
- The final wr_en falls in the last DRAIN cycle, N+PIPE. done pulses in cycle N+PIPE+1, and busy falls in the same cycle.
- Next start is accepted at the earliest in the IDLE cycle N+PIPE+2.

## Configuration
- LAYER_CTRL_PINGPONG_EN defined:
  - A bank register, reset 0, toggles on the cycle done pulses.
  - rd_bank = bank, wr_bank = ~bank. Consecutive layers therefore alternate feature-map BRAMs.
- LAYER_CTRL_PINGPONG_EN undefined: rd_bank tied to 0, wr_bank tied to 1, no bank register.

## Test plan
- Full-run count, FM 4x4, CIN=2, COUT=2, K=3x3, PIPE=5, start at T0 -> exactly 576 rd_en cycles, 32 wr_en pulses, done in cycle 582 only, busy high for cycles 1..581.
- Padding, same config, first tap (y=0,x=0,ky=0,kx=0) -> padding=1, rd_addr=0, load=1. Tap ky=1,kx=1 of that pixel -> padding=0, rd_addr=0. Tap ci=1,ky=1,kx=2 -> rd_addr=17.
- Weight and write addressing, same config -> first tap with oc=1 gives w_addr=18. Pixel (oc=1,y=2,x=3) writes wr_addr=27, exactly 5 cycles after its last tap.
- Handshake, pulse start at cycles 10 and 300 of a run -> no effect. A start held high through DONE is accepted only in IDLE.
- Reset, assert rst at cycle 200 for one cycle -> all outputs at reset values the next cycle, no wr_en afterwards, and a new start gives a clean 576-tap run.
- Ping-pong with macro defined, two back-to-back layers -> rd_bank=0/wr_bank=1 during the first layer, 1/0 during the second. Without the macro -> constant 0/1.

Source files
------------

// File: rtl/layer_ctrl_gen.sv
// layer_ctrl_gen: convolution-layer address and control sequencer.
// Walks oc / y / x / ci / ky / kx (innermost last) at one tap per cycle.
// It produces feature-map read addresses, weight addresses, the padding flag
// and the accumulator-clear (load) strobe. Output-pixel write-backs are
// delayed through a PIPE-deep line to line up with the MAC result.
// Optional feature: define LAYER_CTRL_PINGPONG_EN to alternate the read and
// write feature-map banks on every completed layer. Without it, rd_bank=0
// and wr_bank=1 are fixed.
module layer_ctrl_gen #(
  parameter int FM_W = 6,
  parameter int FM_H = 6,
  parameter int CIN  = 8,
  parameter int COUT = 16,
  parameter int KW   = 3,
  parameter int KH   = 3,
  parameter int PIPE = 5,
  parameter int AW   = 10,
  parameter int WAW  = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  output logic [WAW-1:0] w_addr,
  output logic           padding,
  output logic           load,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic           rd_bank,
  output logic           wr_bank
);

  // Spatial/kernel counters share one width large enough that x+kx cannot
  // overflow; the signed coordinates are one bit wider than that.
  localparam int DMAX_FM = (FM_W > FM_H) ? FM_W : FM_H;
  localparam int DMAX_K  = (KW > KH) ? KW : KH;
  localparam int DMAX    = (DMAX_FM > DMAX_K) ? DMAX_FM : DMAX_K;
  localparam int CNT_W   = $clog2(DMAX) + 1;
  localparam int CW      = CNT_W + 1;
  localparam int CI_W    = $clog2(CIN + 1);
  localparam int OC_W    = $clog2(COUT + 1);
  localparam int DR_W    = $clog2(PIPE + 1);
  localparam int PX      = KW / 2;
  localparam int PY      = KH / 2;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CI_W-1:0]  CI_ONE  = 1;
  localparam logic [OC_W-1:0]  OC_ONE  = 1;
  localparam logic [DR_W-1:0]  DR_ONE  = 1;

  localparam logic [CNT_W-1:0] KX_MAX = CNT_W'(KW - 1);
  localparam logic [CNT_W-1:0] KY_MAX = CNT_W'(KH - 1);
  localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(FM_W - 1);
  localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(FM_H - 1);
  localparam logic [CI_W-1:0]  CI_MAX = CI_W'(CIN - 1);
  localparam logic [OC_W-1:0]  OC_MAX = OC_W'(COUT - 1);
  localparam logic [DR_W-1:0]  DR_MAX = DR_W'(PIPE - 1);

  localparam logic signed [CW-1:0] PX_S   = CW'(PX);
  localparam logic signed [CW-1:0] PY_S   = CW'(PY);
  localparam logic signed [CW-1:0] FM_W_S = CW'(FM_W);
  localparam logic signed [CW-1:0] FM_H_S = CW'(FM_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  kx, ky, x, y;
  logic [CI_W-1:0]   ci;
  logic [OC_W-1:0]   oc;
  logic [DR_W-1:0]   drain_cnt;

  logic              kx_last, ky_last, ci_last, x_last, y_last, oc_last;
  logic              run;
  logic              pix_last;
  logic signed [CW-1:0] ix, iy;
  logic              pad;
  logic [AW-1:0]     rd_lin;
  logic [WAW-1:0]    w_lin;
  logic [AW-1:0]     wb_lin;

  logic              vld_p     [PIPE];
  logic [AW-1:0]     wb_addr_p [PIPE];

  assign kx_last = (kx == KX_MAX);
  assign ky_last = (ky == KY_MAX);
  assign ci_last = (ci == CI_MAX);
  assign x_last  = (x  == X_MAX);
  assign y_last  = (y  == Y_MAX);
  assign oc_last = (oc == OC_MAX);
  assign run     = (state == RUN);

  // Last tap of an output pixel: its address enters the write-back line
  assign pix_last = run && kx_last && ky_last && ci_last;

  // Sequencer: layer state, tap counters and the registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      kx        <= '0;
      ky        <= '0;
      ci        <= '0;
      x         <= '0;
      y         <= '0;
      oc        <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            kx        <= '0;
            ky        <= '0;
            ci        <= '0;
            x         <= '0;
            y         <= '0;
            oc        <= '0;
            drain_cnt <= '0;
          end
        end
        RUN: begin
          if (!kx_last) begin
            kx <= kx + CNT_ONE;
          end else begin
            kx <= '0;
            if (!ky_last) begin
              ky <= ky + CNT_ONE;
            end else begin
              ky <= '0;
              if (!ci_last) begin
                ci <= ci + CI_ONE;
              end else begin
                ci <= '0;
                if (!x_last) begin
                  x <= x + CNT_ONE;
                end else begin
                  x <= '0;
                  if (!y_last) begin
                    y <= y + CNT_ONE;
                  end else begin
                    y <= '0;
                    if (!oc_last) begin
                      oc <= oc + OC_ONE;
                    end else begin
                      oc        <= '0;
                      state     <= DRAIN;
                      drain_cnt <= '0;
                    end
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          // Wait for the last pixel to leave the write-back line
          if (drain_cnt == DR_MAX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DR_ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Tap geometry: signed input coordinates with same-size padding offsets
  assign ix  = $signed({1'b0, x}) + $signed({1'b0, kx}) - PX_S;
  assign iy  = $signed({1'b0, y}) + $signed({1'b0, ky}) - PY_S;
  assign pad = ix[CW-1] || iy[CW-1] || (ix >= FM_W_S) || (iy >= FM_H_S);

  // Linear addresses, deliberately truncated to the port widths
  assign rd_lin = AW'(ci) * AW'(FM_H * FM_W) + AW'(iy) * AW'(FM_W) + AW'(ix);
  assign w_lin  = ((WAW'(oc) * WAW'(CIN) + WAW'(ci)) * WAW'(KH) + WAW'(ky)) * WAW'(KW)
                  + WAW'(kx);
  assign wb_lin = AW'(oc) * AW'(FM_H * FM_W) + AW'(y) * AW'(FM_W) + AW'(x);

  // Tap outputs are only meaningful in RUN and held at zero otherwise
  assign rd_en   = run;
  assign padding = run && pad;
  assign load    = run && (ci == '0) && (ky == '0) && (kx == '0);
  assign rd_addr = (run && !pad) ? rd_lin : '0;
  assign w_addr  = run ? w_lin : '0;

  // ---- write-back delay line: stage p0 captures the pixel on its last tap ----
  // Valid bits are cleared by reset so no stale write survives an abort
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= pix_last;
      for (int i = 1; i < PIPE; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Address payload travels with its valid bit; no reset on data
  always_ff @(posedge clk) begin
    wb_addr_p[0] <= wb_lin;
    for (int i = 1; i < PIPE; i++) wb_addr_p[i] <= wb_addr_p[i-1];
  end

  // ---- write-back output: last stage of the delay line ----
  assign wr_en   = vld_p[PIPE-1];
  assign wr_addr = wr_en ? wb_addr_p[PIPE-1] : '0;

`ifdef LAYER_CTRL_PINGPONG_EN
  logic bank;

  // Swap feature-map banks as each layer completes
  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= 1'b0;
    end else if (done) begin
      bank <= ~bank;
    end
  end

  assign rd_bank = bank;
  assign wr_bank = ~bank;
`else
  assign rd_bank = 1'b0;
  assign wr_bank = 1'b1;
`endif

endmodule
